// File: rtl/heartbeat_gen_pkg.sv
// Shared definitions for heartbeat_gen: FSM state encoding, prescaler divide ratio
// and the counter width helper.
package heartbeat_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PULSE   = 3'd3,
        ST_RECOVER = 3'd4,
        ST_FAULT   = 3'd5
    } hb_state_e;

    localparam int BEAT_W = 16;
    localparam int MISS_W = 4;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/heartbeat_gen_tick_prescaler.sv
// Free-running divide-by-DIV prescaler for heartbeat_gen; emits a one-cycle tick
// on the last count of each period while run is high.
module hb_tick_prescaler
    import heartbeat_gen_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/heartbeat_gen.sv
// Periodic heartbeat source with watchdog enable, timeout retry and sticky fault.
// Define HEARTBEAT_STATS_EN to expose beat/miss counters on o_beat_count/o_miss_count.
module heartbeat_gen
    import heartbeat_gen_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1500,
    parameter int PERIOD_W    = 12,
    parameter int PULSE_TICKS = 2,
    parameter int MAX_RETRY   = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_timeout_evt,
    output logic                o_heartbeat,
    output logic                o_timer_en,
    output logic                o_busy,
    output logic                o_fault,
    output logic [BEAT_W-1:0]   o_beat_count,
    output logic [MISS_W-1:0]   o_miss_count
);

    localparam int DIV     = calc_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int PULSE_W = cnt_width(PULSE_TICKS);

    hb_state_e           state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PULSE_W-1:0]  pulse_q, pulse_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                heartbeat_q, timer_en_q, busy_q, fault_q;

    logic                tick;
    logic                enter_recover;
    logic [PERIOD_W-1:0] eff_period;
    logic [MISS_W-1:0]   miss_inc;

    assign eff_period    = (i_period == '0) ? PERIOD_W'(1) : i_period;
    assign miss_inc      = (miss_q == '1) ? miss_q : miss_q + MISS_W'(1);
    assign enter_recover = i_en && i_timeout_evt &&
                           (state_q == ST_WAIT || state_q == ST_PULSE);

    // Restarting the prescaler on RECOVER entry makes the recovery gap exactly one tick.
    hb_tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .run   (state_q != ST_IDLE),
        .clear (state_q == ST_IDLE || state_q == ST_ARM || enter_recover),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        pulse_d  = pulse_q;
        miss_d   = miss_q;
        if (!i_en) begin
            state_d = ST_IDLE;
            miss_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    state_d  = ST_WAIT;
                    period_d = eff_period;
                end
                ST_WAIT: begin
                    if (i_timeout_evt) begin
                        state_d = ST_RECOVER;
                        miss_d  = miss_inc;
                    end else if (tick) begin
                        if (period_q == PERIOD_W'(1)) begin
                            state_d = ST_PULSE;
                            pulse_d = PULSE_W'(PULSE_TICKS);
                        end else begin
                            period_d = period_q - PERIOD_W'(1);
                        end
                    end
                end
                ST_PULSE: begin
                    if (i_timeout_evt) begin
                        state_d = ST_RECOVER;
                        miss_d  = miss_inc;
                    end else if (tick) begin
                        if (pulse_q == PULSE_W'(1)) begin
                            state_d  = ST_WAIT;
                            miss_d   = '0;
                            period_d = eff_period;
                        end else begin
                            pulse_d = pulse_q - PULSE_W'(1);
                        end
                    end
                end
                ST_RECOVER: begin
                    if (tick) state_d = (int'(miss_q) < MAX_RETRY) ? ST_ARM : ST_FAULT;
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            pulse_q     <= '0;
            miss_q      <= '0;
            heartbeat_q <= 1'b0;
            timer_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            pulse_q     <= pulse_d;
            miss_q      <= miss_d;
            // Outputs follow the state being entered so they line up with it cycle for cycle.
            heartbeat_q <= (state_d == ST_PULSE);
            timer_en_q  <= (state_d == ST_WAIT || state_d == ST_PULSE);
            busy_q      <= (state_d != ST_IDLE);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign o_heartbeat = heartbeat_q;
    assign o_timer_en  = timer_en_q;
    assign o_busy      = busy_q;
    assign o_fault     = fault_q;

`ifdef HEARTBEAT_STATS_EN
    logic [BEAT_W-1:0] beat_q;
    logic              beat_done;

    assign beat_done = i_en && (state_q == ST_PULSE) && !i_timeout_evt && tick &&
                       (pulse_q == PULSE_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       beat_q <= '0;
        else if (beat_done) beat_q <= beat_q + BEAT_W'(1);
    end

    assign o_beat_count = beat_q;
    assign o_miss_count = miss_q;
`else
    assign o_beat_count = '0;
    assign o_miss_count = '0;
`endif

endmodule

// File: tb/tb_heartbeat_gen.sv
// Self-checking bench for heartbeat_gen (DIV=10, PULSE_TICKS=2, MAX_RETRY=3).
// Expected timings are derived arithmetically from period/tick rules.
module tb_heartbeat_gen;

    localparam int DIV       = 10;
    localparam int PT        = 2;
    localparam int MAX_RETRY = 3;
`ifdef HEARTBEAT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        i_rst_n;
    logic        i_en;
    logic [11:0] i_period;
    logic        i_timeout_evt;
    logic        o_heartbeat, o_timer_en, o_busy, o_fault;
    logic [15:0] o_beat_count;
    logic [3:0]  o_miss_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_beat = 0;
    int exp_miss = 0;

    heartbeat_gen #(
        .CLK_FREQ_HZ (100),
        .TICK_HZ     (10),
        .PERIOD_W    (12),
        .PULSE_TICKS (PT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_en),
        .i_period      (i_period),
        .i_timeout_evt (i_timeout_evt),
        .o_heartbeat   (o_heartbeat),
        .o_timer_en    (o_timer_en),
        .o_busy        (o_busy),
        .o_fault       (o_fault),
        .o_beat_count  (o_beat_count),
        .o_miss_count  (o_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    function automatic logic [15:0] want_beat();
        return STATS ? 16'(exp_beat) : 16'd0;
    endfunction

    function automatic logic [3:0] want_miss();
        return STATS ? 4'(exp_miss) : 4'd0;
    endfunction

    function automatic logic sig(input int which);
        case (which)
            0:       return o_heartbeat;
            1:       return o_timer_en;
            default: return o_fault;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until the selected output reaches val; returns budget if it never does.
    task automatic count_until(input int which, input logic val, input int budget, output int n);
        n = 0;
        while (sig(which) !== val && n < budget) begin
            step();
            n++;
        end
    endtask

    // Drop enable for a cycle, then bring the block up to the first WAIT cycle.
    task automatic restart(input int p);
        i_en          = 1'b0;
        i_timeout_evt = 1'b0;
        i_period      = p[11:0];
        step();
        exp_miss = 0;
        i_en = 1'b1;
        step();
        step();
    endtask

    task automatic pulse_timeout();
        i_timeout_evt = 1'b1;
        step();
        i_timeout_evt = 1'b0;
        if (exp_miss < 15) exp_miss++;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_en = 1'b1; i_period = 12'd4; i_timeout_evt = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({o_heartbeat, o_timer_en, o_busy, o_fault, o_beat_count, o_miss_count} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {o_heartbeat, o_timer_en, o_busy, o_fault, o_beat_count, o_miss_count});
        end
        i_rst_n = 1'b1;
        step();
        n_checks++;
        if ({o_busy, o_timer_en} !== 2'b10) begin
            n_fail++; $display("FAIL reset_arm: got busy/timer_en %b expected 10", {o_busy, o_timer_en});
        end
        step();
        n_checks++;
        if ({o_busy, o_timer_en} !== 2'b11) begin
            n_fail++; $display("FAIL reset_wait: got busy/timer_en %b expected 11", {o_busy, o_timer_en});
        end
    endtask

    task automatic test_steady(input int p0, input int nbeats, input bit vary);
        int p, pn, n;
        p = p0;
        restart(p);
        for (int b = 0; b < nbeats; b++) begin
            count_until(0, 1'b1, p * DIV + 5, n);
            n_checks++;
            if (n != p * DIV) begin
                n_fail++; $display("FAIL steady_low: got %0d cycles expected %0d", n, p * DIV);
            end
            pn = vary ? int'($urandom_range(1, 5)) : p;
            i_period = pn[11:0];
            count_until(0, 1'b0, PT * DIV + 5, n);
            n_checks++;
            if (n != PT * DIV) begin
                n_fail++; $display("FAIL steady_high: got %0d cycles expected %0d", n, PT * DIV);
            end
            exp_beat++;
            exp_miss = 0;
            n_checks++;
            if (o_beat_count !== want_beat() || o_miss_count !== want_miss()) begin
                n_fail++;
                $display("FAIL steady_counts: got beat %0d miss %0d expected beat %0d miss %0d",
                         o_beat_count, o_miss_count, want_beat(), want_miss());
            end
            p = pn;
        end
    endtask

    task automatic test_retry();
        int n;
        restart(3);
        repeat ($urandom_range(0, 3 * DIV - 1)) step();
        pulse_timeout();
        n_checks++;
        if ({o_timer_en, o_busy, o_heartbeat} !== 3'b010 || o_miss_count !== want_miss()) begin
            n_fail++;
            $display("FAIL retry_enter: got timer/busy/hb %b miss %0d expected 010 miss %0d",
                     {o_timer_en, o_busy, o_heartbeat}, o_miss_count, want_miss());
        end
        count_until(1, 1'b1, DIV + 5, n);
        n_checks++;
        if (n != DIV + 1) begin
            n_fail++; $display("FAIL retry_timer_low: got %0d cycles expected %0d", n, DIV + 1);
        end
        count_until(0, 1'b1, 3 * DIV + 5, n);
        n_checks++;
        if (n != 3 * DIV) begin
            n_fail++; $display("FAIL retry_rearm_low: got %0d cycles expected %0d", n, 3 * DIV);
        end
        count_until(0, 1'b0, PT * DIV + 5, n);
        exp_beat++;
        exp_miss = 0;
        n_checks++;
        if (o_beat_count !== want_beat() || o_miss_count !== want_miss()) begin
            n_fail++;
            $display("FAIL retry_recovered: got beat %0d miss %0d expected beat %0d miss %0d",
                     o_beat_count, o_miss_count, want_beat(), want_miss());
        end
    endtask

    task automatic test_fault();
        int n;
        restart(2);
        for (int i = 1; i <= MAX_RETRY; i++) begin
            repeat ($urandom_range(0, 2 * DIV - 1)) step();
            pulse_timeout();
            n_checks++;
            if (o_miss_count !== want_miss()) begin
                n_fail++; $display("FAIL fault_miss: got %0d expected %0d", o_miss_count, want_miss());
            end
            if (i < MAX_RETRY) begin
                count_until(1, 1'b1, DIV + 5, n);
                n_checks++;
                if (n != DIV + 1) begin
                    n_fail++; $display("FAIL fault_retry_gap: got %0d cycles expected %0d", n, DIV + 1);
                end
            end else begin
                count_until(2, 1'b1, DIV + 5, n);
                n_checks++;
                if (n != DIV) begin
                    n_fail++; $display("FAIL fault_entry: got %0d cycles expected %0d", n, DIV);
                end
            end
        end
        for (int c = 0; c < 5; c++) begin
            i_timeout_evt = 1'($urandom_range(0, 1));
            step();
        end
        i_timeout_evt = 1'b0;
        n_checks++;
        if ({o_fault, o_timer_en, o_heartbeat, o_busy} !== 4'b1001 || o_miss_count !== want_miss()) begin
            n_fail++;
            $display("FAIL fault_hold: got fault/timer/hb/busy %b miss %0d expected 1001 miss %0d",
                     {o_fault, o_timer_en, o_heartbeat, o_busy}, o_miss_count, want_miss());
        end
        i_en = 1'b0;
        step();
        exp_miss = 0;
        n_checks++;
        if ({o_fault, o_busy} !== 2'b00 || o_miss_count !== want_miss()) begin
            n_fail++;
            $display("FAIL fault_clear: got fault/busy %b miss %0d expected 00 miss 0",
                     {o_fault, o_busy}, o_miss_count);
        end
    endtask

    task automatic test_collision();
        int n, p, idx;
        for (int it = 0; it < 2; it++) begin
            p = $urandom_range(1, 4);
            restart(p);
            count_until(0, 1'b1, p * DIV + 5, n);
            idx = (it == 0) ? int'($urandom_range(0, PT * DIV - 2)) : PT * DIV - 1;
            repeat (idx) step();
            pulse_timeout();
            n_checks++;
            if ({o_heartbeat, o_timer_en} !== 2'b00 || o_beat_count !== want_beat() ||
                o_miss_count !== want_miss()) begin
                n_fail++;
                $display("FAIL collision_%0d: got hb/timer %b beat %0d miss %0d expected 00 beat %0d miss %0d",
                         it, {o_heartbeat, o_timer_en}, o_beat_count, o_miss_count, want_beat(), want_miss());
            end
            count_until(1, 1'b1, DIV + 5, n);
            n_checks++;
            if (n != DIV + 1) begin
                n_fail++; $display("FAIL collision_recover: got %0d cycles expected %0d", n, DIV + 1);
            end
        end
    endtask

    task automatic test_edge();
        int n;
        i_en = 1'b0; i_timeout_evt = 1'b1; i_period = 12'd0;
        step();
        i_en = 1'b1;
        step();
        step();
        i_timeout_evt = 1'b0;
        exp_miss = 0;
        n_checks++;
        if (o_timer_en !== 1'b1 || o_miss_count !== want_miss()) begin
            n_fail++;
            $display("FAIL edge_ignored_timeout: got timer %b miss %0d expected 1 miss 0", o_timer_en, o_miss_count);
        end
        count_until(0, 1'b1, DIV + 5, n);
        n_checks++;
        if (n != DIV) begin
            n_fail++; $display("FAIL edge_period0_first: got %0d cycles expected %0d", n, DIV);
        end
        count_until(0, 1'b0, PT * DIV + 5, n);
        exp_beat++;
        count_until(0, 1'b1, DIV + 5, n);
        n_checks++;
        if (n != DIV) begin
            n_fail++; $display("FAIL edge_period0_low: got %0d cycles expected %0d", n, DIV);
        end
        repeat ($urandom_range(1, PT * DIV - 1)) step();
        i_en = 1'b0;
        step();
        n_checks++;
        if ({o_heartbeat, o_busy, o_timer_en} !== 3'b000 || o_beat_count !== want_beat() ||
            o_miss_count !== want_miss()) begin
            n_fail++;
            $display("FAIL edge_en_drop: got hb/busy/timer %b beat %0d miss %0d expected 000 beat %0d miss 0",
                     {o_heartbeat, o_busy, o_timer_en}, o_beat_count, o_miss_count, want_beat());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        restart(1);
        count_until(0, 1'b1, DIV + 5, n);
        repeat (3) step();
        #2;
        i_rst_n = 1'b0;
        #1;
        exp_beat = 0;
        exp_miss = 0;
        n_checks++;
        if ({o_heartbeat, o_timer_en, o_busy, o_fault, o_beat_count, o_miss_count} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %0h expected 0",
                     {o_heartbeat, o_timer_en, o_busy, o_fault, o_beat_count, o_miss_count});
        end
        #2;
        i_rst_n = 1'b1;
        step();
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_restart: got busy %b expected 1", o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_steady(4, 3, 1'b0);
        test_steady($urandom_range(1, 5), 3, 1'b1);
        test_retry();
        test_fault();
        test_collision();
        test_edge();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
